// File: rtl/approx_denormalizer_if.sv
// Handshake bundle for approx_denormalizer: mantissa/shift request in, expanded result out.
// The master side drives requests and consumes results; the slave side is the engine.
interface approx_denormalizer_if #(
  parameter int unsigned MANT_W = 16,
  parameter int unsigned SH_W   = 5,
  parameter int unsigned RES_W  = 2 * MANT_W
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant;
  logic [SH_W-1:0]   shamt;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  result;
  logic              busy;

  modport master (
    output in_valid,
    input  in_ready,
    output mant,
    output shamt,
    input  out_valid,
    output out_ready,
    input  result,
    input  busy
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  mant,
    input  shamt,
    output out_valid,
    input  out_ready,
    output result,
    output busy
  );
endinterface

// File: rtl/approx_denormalizer.sv
// Sequential denormalizer: expands {mant, shamt} to ({mant,0} >> shamt), one shift per clock.
// Define APPROX_DENORM_ROUND_EN to round half-up on the final shift.
module approx_denormalizer #(
  parameter int unsigned MANT_W = 16,
  parameter int unsigned SH_W   = 5,
  parameter int unsigned RES_W  = 2 * MANT_W
) (
  input logic                 clk,
  input logic                 rst,
  approx_denormalizer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [SH_W-1:0]   count_q, count_d;
  logic [RES_W-1:0]  shifted;

  assign shifted = result_q >> 1;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          result_d = {bus.mant, {MANT_W{1'b0}}};
          count_d  = bus.shamt;
          state_d  = (bus.shamt != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        result_d = shifted;
        count_d  = count_q - SH_W'(1);
        if (count_q == SH_W'(1)) begin
          state_d = StDone;
`ifdef APPROX_DENORM_ROUND_EN
          // MSB is already zero after a shift, so the increment cannot wrap.
          result_d = shifted + RES_W'(result_q[0]);
`endif
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_approx_denormalizer.sv
// Directed bench for approx_denormalizer with hand-computed results; honours
// APPROX_DENORM_ROUND_EN for the rounding-sensitive vectors.
module tb_approx_denormalizer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  approx_denormalizer_if #(.MANT_W(16), .SH_W(5), .RES_W(32)) bus ();

  approx_denormalizer #(.MANT_W(16), .SH_W(5), .RES_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with out_ready high, check latency, result, and return to idle.
  task automatic run_txn(input string tag, input logic [15:0] m, input logic [4:0] n,
                         input logic [31:0] exp);
    int edges;
    check({tag, " in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.mant      = m;
    bus.shamt     = n;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.mant     = 16'h5A5A;
    bus.shamt    = 5'd7;
    edges = 1;
    while (!bus.out_valid && edges < 200) begin
      step();
      edges++;
    end
    check({tag, " latency"}, edges, 32'(n) + 32'd1);
    check({tag, " result"}, bus.result, exp);
    step();
    check({tag, " idle out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, " idle in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    check({tag, " idle result held"}, bus.result, exp);
  endtask

  logic [31:0] exp_max;
  logic [31:0] exp_under;

  initial begin
`ifdef APPROX_DENORM_ROUND_EN
    exp_max   = 32'h0000_0002;
    exp_under = 32'h0000_0001;
`else
    exp_max   = 32'h0000_0001;
    exp_under = 32'h0000_0000;
`endif
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mant      = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset result", bus.result, 32'h0);
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset busy", {31'b0, bus.busy}, 32'd0);

    // Reset in the middle of a long shift.
    bus.in_valid = 1'b1;
    bus.mant     = 16'h1234;
    bus.shamt    = 5'd10;
    step();
    bus.in_valid = 1'b0;
    check("midshift busy", {31'b0, bus.busy}, 32'd1);
    check("midshift in_ready", {31'b0, bus.in_ready}, 32'd0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst mid result", bus.result, 32'h0);
    check("rst mid out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst mid in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst mid busy", {31'b0, bus.busy}, 32'd0);

    run_txn("basic", 16'h00C8, 5'd3, 32'h0019_0000);
    run_txn("zero", 16'hFFFF, 5'd0, 32'hFFFF_0000);
    run_txn("max", 16'hFFFF, 5'd31, exp_max);
    run_txn("under", 16'h0001, 5'd17, exp_under);
    run_txn("mid", 16'hABCD, 5'd8, 32'h00AB_CD00);

    // Backpressure: hold DONE while a new request waits.
    bus.in_valid  = 1'b1;
    bus.mant      = 16'h8000;
    bus.shamt     = 5'd1;
    bus.out_ready = 1'b0;
    step();
    bus.mant  = 16'hAAAA;
    bus.shamt = 5'd4;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp result", bus.result, 32'h4000_0000);
      check("bp in_ready", {31'b0, bus.in_ready}, 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("bp released idle", {31'b0, bus.in_ready}, 32'd1);
    check("bp released result", bus.result, 32'h4000_0000);
    step();
    bus.in_valid = 1'b0;
    check("bp second accepted", {31'b0, bus.busy}, 32'd1);
    check("bp second loaded", bus.result, 32'hAAAA_0000);
    repeat (4) step();
    check("bp second valid", {31'b0, bus.out_valid}, 32'd1);
    check("bp second result", bus.result, 32'h0AAA_A000);
    step();
    check("bp second idle", {31'b0, bus.in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
